vga_tlight_seq: RTL

- Parametrised traffic-light sequencer rendered on VGA; generalises the single-colour-fill traffic light.
- Draws a housing with three stacked lamps (red top, yellow middle, green bottom). The active lamp is lit and the others are dimmed.
- Phase timing is counted in whole frames, so phase changes occur only during vertical blanking.
- A latched pedestrian request shortens green after a minimum green time.
- Instantiates vga_sync internally and sits directly above the VGA pin driver.

---
 rtl/vga_tlight_seq.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_tlight_seq.sv
// Traffic-light sequencer drawn on VGA: three stacked lamps in a housing, phase
// timing counted in whole frames, with a latched pedestrian request that shortens green.

module vga_sync #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int H_WHOLE_LINE  = 800,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int V_WHOLE_FRAME = 525,
  localparam int X_W = $clog2(H_WHOLE_LINE),
  localparam int Y_W = $clog2(V_WHOLE_FRAME)
) (
  input  logic           clk,
  input  logic           reset,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           visible,
  output logic           hsync,
  output logic           vsync
);
  if (H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH != H_WHOLE_LINE ||
      V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH != V_WHOLE_FRAME) begin : g_bad_mode
    $error("vga_sync: porch/sync/visible widths do not add up to the whole line/frame");
  end

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == X_W'(H_WHOLE_LINE - 1)) begin
      x_d = '0;
      y_d = (y_q == Y_W'(V_WHOLE_FRAME - 1)) ? '0 : y_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Syncs are active low.
  assign x       = x_q;
  assign y       = y_q;
  assign visible = (x_q < X_W'(H_VISIBLE)) && (y_q < Y_W'(V_VISIBLE));
  assign hsync   = ~((x_q >= X_W'(H_VISIBLE + H_FRONT_PORCH)) &&
                     (x_q <  X_W'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE)));
  assign vsync   = ~((y_q >= Y_W'(V_VISIBLE + V_FRONT_PORCH)) &&
                     (y_q <  Y_W'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE)));
endmodule

module vga_tlight_seq #(
  parameter int PIXEL_BITS       = 12,
  parameter int H_VISIBLE        = 640,
  parameter int H_FRONT_PORCH    = 16,
  parameter int H_SYNC_PULSE     = 96,
  parameter int H_BACK_PORCH     = 48,
  parameter int H_WHOLE_LINE     = 800,
  parameter int V_VISIBLE        = 480,
  parameter int V_FRONT_PORCH    = 10,
  parameter int V_SYNC_PULSE     = 2,
  parameter int V_BACK_PORCH     = 33,
  parameter int V_WHOLE_FRAME    = 525,
  parameter int RED_FRAMES       = 240,
  parameter int GREEN_FRAMES     = 240,
  parameter int YELLOW_FRAMES    = 60,
  parameter int MIN_GREEN_FRAMES = 60,
  parameter int LAMP_SIZE        = 64,
  parameter int LAMP_GAP         = 16,
  localparam int COLOR_BITS      = PIXEL_BITS / 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ped_req,
  output logic                  ped_ack,
  output logic [1:0]            phase,
  output logic [COLOR_BITS-1:0] vga_red,
  output logic [COLOR_BITS-1:0] vga_grn,
  output logic [COLOR_BITS-1:0] vga_blu,
  output logic                  vga_hsync,
  output logic                  vga_vsync
);
  if (RED_FRAMES < 1 || GREEN_FRAMES < 1 || YELLOW_FRAMES < 1 ||
      MIN_GREEN_FRAMES < 1 || MIN_GREEN_FRAMES > GREEN_FRAMES) begin : g_bad_timing
    $error("vga_tlight_seq: phase durations must be >= 1 and MIN_GREEN_FRAMES <= GREEN_FRAMES");
  end

  localparam int X_W     = $clog2(H_WHOLE_LINE);
  localparam int Y_W     = $clog2(V_WHOLE_FRAME);
  localparam int MAX_DUR = (RED_FRAMES > GREEN_FRAMES)
                         ? ((RED_FRAMES > YELLOW_FRAMES) ? RED_FRAMES : YELLOW_FRAMES)
                         : ((GREEN_FRAMES > YELLOW_FRAMES) ? GREEN_FRAMES : YELLOW_FRAMES);
  localparam int CNT_W   = ($clog2(MAX_DUR) < 1) ? 1 : $clog2(MAX_DUR);
  localparam int PITCH   = LAMP_SIZE + LAMP_GAP;
  localparam int STACK_H = 3 * LAMP_SIZE + 2 * LAMP_GAP;
  localparam int X0      = (H_VISIBLE - LAMP_SIZE) / 2;
  localparam int Y0      = (V_VISIBLE - STACK_H) / 2;
  localparam logic [COLOR_BITS-1:0] C_MAX = '1;
  localparam logic [COLOR_BITS-1:0] C_DIM = C_MAX >> 2;
  localparam logic [COLOR_BITS-1:0] C_ONE = COLOR_BITS'(1);

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  logic [X_W-1:0] vs_x;
  logic [Y_W-1:0] vs_y;
  logic           vs_visible, vs_hsync, vs_vsync;

  vga_sync #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT_PORCH(H_FRONT_PORCH), .H_SYNC_PULSE(H_SYNC_PULSE),
    .H_BACK_PORCH(H_BACK_PORCH), .H_WHOLE_LINE(H_WHOLE_LINE),
    .V_VISIBLE(V_VISIBLE), .V_FRONT_PORCH(V_FRONT_PORCH), .V_SYNC_PULSE(V_SYNC_PULSE),
    .V_BACK_PORCH(V_BACK_PORCH), .V_WHOLE_FRAME(V_WHOLE_FRAME)
  ) u_sync (
    .clk(clk), .reset(reset), .x(vs_x), .y(vs_y),
    .visible(vs_visible), .hsync(vs_hsync), .vsync(vs_vsync)
  );

  phase_e                phase_q, phase_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  pending_q, pending_d;
  logic                  ped_ack_q, ped_ack_d;
  logic [COLOR_BITS-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                  hsync_q, vsync_q;
  logic                  frame_tick;

  // First blanking line start: phase changes never land on visible pixels.
  assign frame_tick = (vs_x == '0) && (vs_y == Y_W'(V_VISIBLE));

  always_comb begin
    phase_d     = phase_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    ped_ack_d   = 1'b0;
    if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      case (phase_q)
        PH_RED:
          if (frame_cnt_q == CNT_W'(RED_FRAMES - 1)) begin
            phase_d     = PH_GREEN;
            frame_cnt_d = '0;
          end
        PH_GREEN:
          if ((pending_q && frame_cnt_q >= CNT_W'(MIN_GREEN_FRAMES - 1)) ||
              frame_cnt_q == CNT_W'(GREEN_FRAMES - 1)) begin
            phase_d     = PH_YELLOW;
            frame_cnt_d = '0;
          end
        default:
          if (frame_cnt_q == CNT_W'(YELLOW_FRAMES - 1)) begin
            phase_d     = PH_RED;
            frame_cnt_d = '0;
            ped_ack_d   = pending_q;
            pending_d   = 1'b0;
          end
      endcase
    end
    // A request landing on the clearing cycle survives for the next green.
    if (ped_req) pending_d = 1'b1;
  end

  int         xi, yi;
  logic [2:0] in_lamp;
  logic       in_house;

  always_comb begin
    xi       = int'(vs_x);
    yi       = int'(vs_y);
    in_lamp  = '0;
    in_house = (xi >= X0 - LAMP_GAP) && (xi < X0 + LAMP_SIZE + LAMP_GAP) &&
               (yi >= Y0 - LAMP_GAP) && (yi < Y0 + STACK_H + LAMP_GAP);
    for (int k = 0; k < 3; k++)
      in_lamp[k] = (xi >= X0) && (xi < X0 + LAMP_SIZE) &&
                   (yi >= Y0 + k * PITCH) && (yi < Y0 + k * PITCH + LAMP_SIZE);
  end

  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (vs_visible) begin
      if (in_lamp[0]) begin
        red_d = (phase_q == PH_RED) ? C_MAX : C_DIM;
      end else if (in_lamp[1]) begin
        red_d = (phase_q == PH_YELLOW) ? C_MAX : C_DIM;
        grn_d = red_d;
      end else if (in_lamp[2]) begin
        grn_d = (phase_q == PH_GREEN) ? C_MAX : C_DIM;
      end else if (in_house) begin
        red_d = C_ONE;
        grn_d = C_ONE;
        blu_d = C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PH_RED;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      ped_ack_q   <= 1'b0;
      red_q       <= '0;
      grn_q       <= '0;
      blu_q       <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      phase_q     <= phase_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      ped_ack_q   <= ped_ack_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      blu_q       <= blu_d;
      hsync_q     <= vs_hsync;
      vsync_q     <= vs_vsync;
    end
  end

  assign phase     = phase_q;
  assign ped_ack   = ped_ack_q;
  assign vga_red   = red_q;
  assign vga_grn   = grn_q;
  assign vga_blu   = blu_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
endmodule
